ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS pipeline. It consumes the ID/EX buffer outputs every cycle: ALU operation, branch-target adder, destination-register select. It registers its results into the EX/MEM fields. It also contains an iterative 32-cycle signed multiply/divide unit with HI/LO registers, and raises a stall toward the front of the pipeline while that unit is busy.

## Interface
- No parameters; data width fixed at 32.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_read_rb_1, i_read_rb_2  in  32 each  register operands A and B
- i_rt, i_rd  in  5 each  candidate destination registers
- i_address_pc  in  32  PC+4 of the instruction
- i_ext_sign  in  32  sign-extended immediate; [5:0] is funct for R-type
- i_jump_address  in  32  jump target, passed through
- i_branch, i_memRead, i_memWrite, i_regWrite, i_memToReg, i_jump  in  1 each  control, passed through
- i_aluOp  in  3  ALU operation class
- i_aluSrc  in  1  1 selects i_ext_sign as operand B
- i_regDst  in  1  1 selects i_rd as destination
- o_alu_result  out  32  registered ALU / mfhi / mflo result
- o_write_data  out  32  registered i_read_rb_2 (store data)
- o_write_reg  out  5  registered destination register
- o_branch_target  out  32  registered i_address_pc + (i_ext_sign << 2)
- o_zero  out  1  registered (ALU result == 0)
- o_jump_address, o_branch, o_memRead, o_memWrite, o_regWrite, o_memToReg, o_jump  out  registered passthroughs
- o_stall  out  1  registered; multiply/divide unit busy

## Operation
- i_aluOp decode:
  - 000 add
  - 001 sub
  - 010 R-type by funct
  - 011 and
  - 100 or
  - 101 slt (signed)
  - 110 lui (B << 16)
  - 111 add
- Operand B is i_ext_sign when i_aluSrc=1, otherwise i_read_rb_2.
- Funct decode:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt
  - 0x10 mfhi, 0x12 mflo
  - 0x18 mult, 0x1A div
  - any other funct: add
- Arithmetic wraps modulo 2^32. No overflow traps.
- States: IDLE and BUSY.
- In IDLE, a valid mult/div (R-type, funct 0x18 or 0x1A):
  - latches A, B and the operation;
  - clears the counter and moves to BUSY;
  - drives a bubble into EX/MEM: regWrite, memRead, memWrite, branch and jump all 0, data fields 0.
- BUSY:
  - one iteration per cycle; counter runs 0..31;
  - on the edge where counter==31, HI/LO are written and the state returns to IDLE;
  - inputs are ignored; every EX/MEM output is a bubble.
- mult: signed 64-bit product; HI = [63:32], LO = [31:0].
- div: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- div boundary cases:
  - divide by zero: LO=0xFFFFFFFF, HI=dividend;
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- o_write_reg = i_rd if i_regDst=1, else i_rt.
- rst in any state:
  - every output and HI/LO go to 0; state goes to IDLE; counter clears;
  - an in-flight operation is discarded and o_stall deasserts at that edge.
- Upstream (PC, IF/ID, ID/EX) must freeze while o_stall=1. The block does not buffer the held instruction.

## Timing
- Non-mult/div instruction present in cycle N: results appear on outputs after edge N (latency 1).
- mult/div captured at edge N:
  - o_stall=1 from after edge N through edge N+32;
  - o_stall=0 after edge N+32;
  - HI/LO valid from cycle N+32 onward.
- The instruction held in ID/EX during the stall is consumed at edge N+32. mfhi/mflo in that slot sees the new HI/LO.
- All outputs reset to 0, including o_stall.

## Test plan
- Reset: assert rst for 2 cycles with random inputs → all outputs 0, o_stall=0. Then mflo → o_alu_result=0.
- R-type sub:
  - A=5, B=7, funct 0x22, regDst=1, rd=9 → o_alu_result=0xFFFFFFFE, o_write_reg=9, o_zero=0 next cycle.
  - Then slt on the same operands → o_alu_result=1.
- I-type with branch:
  - aluSrc=1, i_ext_sign=0xFFFFFFFC, pc=0x100, aluOp=000, A=0x10 → o_alu_result=0xC, o_branch_target=0xF0, o_write_reg=rt.
- mult:
  - A=-3, B=0x10000 → o_stall high exactly 32 cycles, outputs are bubbles;
  - then mfhi=0xFFFFFFFF, mflo=0xFFFD0000.
- div corners:
  - -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF;
  - 5/0 → LO=0xFFFFFFFF, HI=5;
  - 0x80000000/-1 → LO=0x80000000, HI=0.
- Reset mid-div: assert rst at counter=10 → o_stall=0 next cycle, HI=LO=0, next add executes normally with latency 1.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the MIPS execute stage.
// The execute stage is the slave; the pipeline around it is the master.
interface ex_stage_if;
  logic [31:0] i_read_rb_1;
  logic [31:0] i_read_rb_2;
  logic [4:0]  i_rt;
  logic [4:0]  i_rd;
  logic [31:0] i_address_pc;
  logic [31:0] i_ext_sign;
  logic [31:0] i_jump_address;
  logic        i_branch;
  logic        i_memRead;
  logic        i_memWrite;
  logic        i_regWrite;
  logic        i_memToReg;
  logic        i_jump;
  logic [2:0]  i_aluOp;
  logic        i_aluSrc;
  logic        i_regDst;

  logic [31:0] o_alu_result;
  logic [31:0] o_write_data;
  logic [4:0]  o_write_reg;
  logic [31:0] o_branch_target;
  logic        o_zero;
  logic [31:0] o_jump_address;
  logic        o_branch;
  logic        o_memRead;
  logic        o_memWrite;
  logic        o_regWrite;
  logic        o_memToReg;
  logic        o_jump;
  logic        o_stall;

  modport slave (
    input  i_read_rb_1, i_read_rb_2, i_rt, i_rd, i_address_pc, i_ext_sign,
           i_jump_address, i_branch, i_memRead, i_memWrite, i_regWrite,
           i_memToReg, i_jump, i_aluOp, i_aluSrc, i_regDst,
    output o_alu_result, o_write_data, o_write_reg, o_branch_target, o_zero,
           o_jump_address, o_branch, o_memRead, o_memWrite, o_regWrite,
           o_memToReg, o_jump, o_stall
  );

  modport master (
    output i_read_rb_1, i_read_rb_2, i_rt, i_rd, i_address_pc, i_ext_sign,
           i_jump_address, i_branch, i_memRead, i_memWrite, i_regWrite,
           i_memToReg, i_jump, i_aluOp, i_aluSrc, i_regDst,
    input  o_alu_result, o_write_data, o_write_reg, o_branch_target, o_zero,
           o_jump_address, o_branch, o_memRead, o_memWrite, o_regWrite,
           o_memToReg, o_jump, o_stall
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch-target adder, destination select, and an
// iterative 32-cycle signed multiply/divide unit with HI/LO registers.
module ex_stage (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0, OP_SUB  = 3'd1, OP_AND  = 3'd2, OP_OR   = 3'd3,
    OP_SLT  = 3'd4, OP_LUI  = 3'd5, OP_MFHI = 3'd6, OP_MFLO = 3'd7
  } alu_op_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = v[31] ? (32'd0 - v) : v;
  endfunction

  state_t      state_r, state_next_s;
  alu_op_t     op_s;
  logic [4:0]  cnt_r;
  logic        is_div_r, a_neg_r, b_neg_r, dvz_r;
  logic [31:0] dividend_r, mcand_r, hi_r, lo_r;
  logic [63:0] acc_r, acc_next_s, prod_s;
  logic [32:0] mul_sum_s, div_sh_s;
  logic [31:0] div_rem_s;
  logic        div_ge_s;
  logic [31:0] hi_new_s, lo_new_s, hi_fwd_s, lo_fwd_s;
  logic [31:0] b_s, result_s;
  logic [5:0]  funct_s;
  logic        muldiv_s, last_s, exec_s, start_s;

  // Operand B select and ALU operation decode.
  always_comb begin
    b_s      = bus.i_aluSrc ? bus.i_ext_sign : bus.i_read_rb_2;
    funct_s  = bus.i_ext_sign[5:0];
    muldiv_s = 1'b0;
    op_s     = OP_ADD;
    case (bus.i_aluOp)
      3'b000: op_s = OP_ADD;
      3'b001: op_s = OP_SUB;
      3'b011: op_s = OP_AND;
      3'b100: op_s = OP_OR;
      3'b101: op_s = OP_SLT;
      3'b110: op_s = OP_LUI;
      3'b111: op_s = OP_ADD;
      3'b010: begin
        case (funct_s)
          6'h20:        op_s = OP_ADD;
          6'h22:        op_s = OP_SUB;
          6'h24:        op_s = OP_AND;
          6'h25:        op_s = OP_OR;
          6'h2A:        op_s = OP_SLT;
          6'h10:        op_s = OP_MFHI;
          6'h12:        op_s = OP_MFLO;
          6'h18, 6'h1A: muldiv_s = 1'b1;
          default:      op_s = OP_ADD;
        endcase
      end
      default: op_s = OP_ADD;
    endcase
  end

  // One iteration on magnitudes: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, mcand_r} : 33'd0);
    div_sh_s  = {acc_r[63:32], acc_r[31]};
    div_ge_s  = (div_sh_s >= {1'b0, mcand_r});
    // The true remainder is below the divisor, so 32 bits cannot overflow.
    div_rem_s = div_ge_s ? (div_sh_s[31:0] - mcand_r) : div_sh_s[31:0];
    if (is_div_r) begin
      acc_next_s = {div_rem_s, acc_r[30:0], div_ge_s};
    end else begin
      acc_next_s = {mul_sum_s, acc_r[31:1]};
    end
  end

  // Sign correction and divide corner cases for the final HI/LO write.
  always_comb begin
    prod_s = (a_neg_r ^ b_neg_r) ? (64'd0 - acc_next_s) : acc_next_s;
    if (is_div_r) begin
      if (dvz_r) begin
        lo_new_s = 32'hFFFF_FFFF;
        hi_new_s = dividend_r;
      end else begin
        lo_new_s = (a_neg_r ^ b_neg_r) ? (32'd0 - acc_next_s[31:0]) : acc_next_s[31:0];
        hi_new_s = a_neg_r ? (32'd0 - acc_next_s[63:32]) : acc_next_s[63:32];
      end
    end else begin
      hi_new_s = prod_s[63:32];
      lo_new_s = prod_s[31:0];
    end
  end

  // Sequencing: the held instruction executes on the final busy edge with new HI/LO.
  always_comb begin
    last_s       = (state_r == BUSY) && (cnt_r == 5'd31);
    exec_s       = (state_r == IDLE) || last_s;
    start_s      = exec_s && muldiv_s;
    hi_fwd_s     = last_s ? hi_new_s : hi_r;
    lo_fwd_s     = last_s ? lo_new_s : lo_r;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_next_s = BUSY;
        else         state_next_s = IDLE;
      end
      BUSY: begin
        if (last_s && !start_s) state_next_s = IDLE;
        else                    state_next_s = BUSY;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // ALU result mux.
  always_comb begin
    result_s = 32'd0;
    case (op_s)
      OP_ADD:  result_s = bus.i_read_rb_1 + b_s;
      OP_SUB:  result_s = bus.i_read_rb_1 - b_s;
      OP_AND:  result_s = bus.i_read_rb_1 & b_s;
      OP_OR:   result_s = bus.i_read_rb_1 | b_s;
      OP_SLT:  result_s = {31'd0, ($signed(bus.i_read_rb_1) < $signed(b_s))};
      OP_LUI:  result_s = {b_s[15:0], 16'd0};
      OP_MFHI: result_s = hi_fwd_s;
      OP_MFLO: result_s = lo_fwd_s;
      default: result_s = bus.i_read_rb_1 + b_s;
    endcase
  end

  // Multiply/divide state, iteration counter and latched operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 5'd0;
      acc_r      <= 64'd0;
      mcand_r    <= 32'd0;
      dividend_r <= 32'd0;
      is_div_r   <= 1'b0;
      a_neg_r    <= 1'b0;
      b_neg_r    <= 1'b0;
      dvz_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (start_s) begin
        cnt_r      <= 5'd0;
        is_div_r   <= (funct_s == 6'h1A);
        a_neg_r    <= bus.i_read_rb_1[31];
        b_neg_r    <= b_s[31];
        dividend_r <= bus.i_read_rb_1;
        dvz_r      <= (b_s == 32'd0);
        if (funct_s == 6'h1A) begin
          acc_r   <= {32'd0, abs32(bus.i_read_rb_1)};
          mcand_r <= abs32(b_s);
        end else begin
          acc_r   <= {32'd0, abs32(b_s)};
          mcand_r <= abs32(bus.i_read_rb_1);
        end
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r + 5'd1;
        acc_r <= acc_next_s;
      end
    end
  end

  // HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (last_s) begin
      hi_r <= hi_new_s;
      lo_r <= lo_new_s;
    end
  end

  // EX/MEM register: real results when an instruction executes, else a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_alu_result    <= 32'd0;
      bus.o_write_data    <= 32'd0;
      bus.o_write_reg     <= 5'd0;
      bus.o_branch_target <= 32'd0;
      bus.o_zero          <= 1'b0;
      bus.o_jump_address  <= 32'd0;
      bus.o_branch        <= 1'b0;
      bus.o_memRead       <= 1'b0;
      bus.o_memWrite      <= 1'b0;
      bus.o_regWrite      <= 1'b0;
      bus.o_memToReg      <= 1'b0;
      bus.o_jump          <= 1'b0;
      bus.o_stall         <= 1'b0;
    end else begin
      bus.o_stall <= (state_next_s == BUSY);
      if (exec_s && !muldiv_s) begin
        bus.o_alu_result    <= result_s;
        bus.o_write_data    <= bus.i_read_rb_2;
        bus.o_write_reg     <= bus.i_regDst ? bus.i_rd : bus.i_rt;
        bus.o_branch_target <= bus.i_address_pc + {bus.i_ext_sign[29:0], 2'b00};
        bus.o_zero          <= (result_s == 32'd0);
        bus.o_jump_address  <= bus.i_jump_address;
        bus.o_branch        <= bus.i_branch;
        bus.o_memRead       <= bus.i_memRead;
        bus.o_memWrite      <= bus.i_memWrite;
        bus.o_regWrite      <= bus.i_regWrite;
        bus.o_memToReg      <= bus.i_memToReg;
        bus.o_jump          <= bus.i_jump;
      end else begin
        bus.o_alu_result    <= 32'd0;
        bus.o_write_data    <= 32'd0;
        bus.o_write_reg     <= 5'd0;
        bus.o_branch_target <= 32'd0;
        bus.o_zero          <= 1'b0;
        bus.o_jump_address  <= 32'd0;
        bus.o_branch        <= 1'b0;
        bus.o_memRead       <= 1'b0;
        bus.o_memWrite      <= 1'b0;
        bus.o_regWrite      <= 1'b0;
        bus.o_memToReg      <= 1'b0;
        bus.o_jump          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: an instruction-level model predicts every
// EX/MEM output each cycle; literal expectations pin key results.
module tb_ex_stage;

  logic clk;
  logic rst;
  ex_stage_if bus();

  ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] bt;
    logic [31:0] jaddr;
    logic [4:0]  wreg;
    logic        zero;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        memtoreg;
    logic        jump;
    logic        stall;
  } exp_t;

  // model state
  exp_t        m_exp;
  logic [31:0] m_hi, m_lo, p_hi, p_lo, m_a, m_b;
  logic [5:0]  m_f;
  logic        m_md, m_run;
  int          m_busy, m_sa, m_sb;
  logic [63:0] m_pv, m_qv, m_rv;
  longint      m_q, m_r;

  // compare state
  int total = 0;
  int bad = 0;
  int stall_run = 0;
  int tmo_seen = 0;

  // driver state
  int          tmo_cnt = 0;
  logic        pa_en, pw_en, pb_en, pz_en;
  logic [31:0] pa_v, pb_v;
  logic [4:0]  pw_v;
  logic        pz_v;

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      3'd1: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return b << 16;
      3'd2: begin
        case (f)
          6'h22:   return a - b;
          6'h24:   return a & b;
          6'h25:   return a | b;
          6'h2A:   return (sa < sb) ? 32'd1 : 32'd0;
          6'h10:   return hi;
          6'h12:   return lo;
          default: return a + b;
        endcase
      end
      default: return a + b;
    endcase
  endfunction

  // Instruction-level model: a mult/div blocks the stage for 32 edges.
  always @(posedge clk) begin
    if (rst) begin
      m_exp  = '0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_busy = 0;
    end else begin
      m_run = (m_busy <= 1);
      if (m_busy == 1) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      if (m_busy > 0) m_busy = m_busy - 1;
      m_a  = bus.i_read_rb_1;
      m_b  = bus.i_aluSrc ? bus.i_ext_sign : bus.i_read_rb_2;
      m_f  = bus.i_ext_sign[5:0];
      m_md = (bus.i_aluOp == 3'd2) && (m_f == 6'h18 || m_f == 6'h1A);
      m_exp = '0;
      if (m_run && m_md) begin
        m_sa = m_a;
        m_sb = m_b;
        if (m_f == 6'h18) begin
          m_pv = longint'(m_sa) * longint'(m_sb);
          p_hi = m_pv[63:32];
          p_lo = m_pv[31:0];
        end else if (m_b == 32'd0) begin
          p_lo = 32'hFFFF_FFFF;
          p_hi = m_a;
        end else begin
          m_q  = longint'(m_sa) / longint'(m_sb);
          m_r  = longint'(m_sa) % longint'(m_sb);
          m_qv = m_q;
          m_rv = m_r;
          p_lo = m_qv[31:0];
          p_hi = m_rv[31:0];
        end
        m_busy = 32;
      end else if (m_run) begin
        m_exp.alu      = alu_model(bus.i_aluOp, m_f, m_a, m_b, m_hi, m_lo);
        m_exp.wdata    = bus.i_read_rb_2;
        m_exp.bt       = bus.i_address_pc + bus.i_ext_sign * 32'd4;
        m_exp.jaddr    = bus.i_jump_address;
        m_exp.wreg     = bus.i_regDst ? bus.i_rd : bus.i_rt;
        m_exp.zero     = (m_exp.alu == 32'd0);
        m_exp.branch   = bus.i_branch;
        m_exp.memread  = bus.i_memRead;
        m_exp.memwrite = bus.i_memWrite;
        m_exp.regwrite = bus.i_regWrite;
        m_exp.memtoreg = bus.i_memToReg;
        m_exp.jump     = bus.i_jump;
      end
      m_exp.stall = (m_busy != 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // Per-cycle compare against the model, plus literal pins and stall length.
  always @(posedge clk) begin
    #1;
    chk("alu_result", bus.o_alu_result, m_exp.alu);
    chk("write_data", bus.o_write_data, m_exp.wdata);
    chk("branch_target", bus.o_branch_target, m_exp.bt);
    chk("jump_address", bus.o_jump_address, m_exp.jaddr);
    chk("write_reg", {27'd0, bus.o_write_reg}, {27'd0, m_exp.wreg});
    chk("zero", {31'd0, bus.o_zero}, {31'd0, m_exp.zero});
    chk("ctl", {26'd0, bus.o_branch, bus.o_memRead, bus.o_memWrite, bus.o_regWrite,
                bus.o_memToReg, bus.o_jump},
        {26'd0, m_exp.branch, m_exp.memread, m_exp.memwrite, m_exp.regwrite,
         m_exp.memtoreg, m_exp.jump});
    chk("stall", {31'd0, bus.o_stall}, {31'd0, m_exp.stall});
    if (!rst && !m_exp.stall) begin
      if (pa_en) begin
        chk("pin_alu", bus.o_alu_result, pa_v);
        chk("model_alu", m_exp.alu, pa_v);
      end
      if (pw_en) chk("pin_write_reg", {27'd0, bus.o_write_reg}, {27'd0, pw_v});
      if (pb_en) chk("pin_branch_target", bus.o_branch_target, pb_v);
      if (pz_en) chk("pin_zero", {31'd0, bus.o_zero}, {31'd0, pz_v});
    end
    if (bus.o_stall === 1'b1) begin
      stall_run++;
    end else begin
      if (stall_run != 0 && !rst) chk("stall_len", stall_run, 32'd32);
      stall_run = 0;
    end
    if (tmo_cnt != tmo_seen) begin
      chk("stall_wait_bound", tmo_cnt, tmo_seen);
      tmo_seen = tmo_cnt;
    end
  end

  task automatic pins(input logic ae, input logic [31:0] av, input logic we, input logic [4:0] wv,
                      input logic be, input logic [31:0] bv, input logic ze, input logic zv);
    pa_en = ae; pa_v = av;
    pw_en = we; pw_v = wv;
    pb_en = be; pb_v = bv;
    pz_en = ze; pz_v = zv;
  endtask

  task automatic nopins();
    pins(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic pin_alu(input logic [31:0] v);
    pins(1'b1, v, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic setin(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ext, input logic [31:0] pc, input logic src,
                       input logic dst, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [5:0] ctl);
    bus.i_aluOp        = op;
    bus.i_read_rb_1    = a;
    bus.i_read_rb_2    = b;
    bus.i_ext_sign     = ext;
    bus.i_address_pc   = pc;
    bus.i_jump_address = pc + 32'h0000_1000;
    bus.i_aluSrc       = src;
    bus.i_regDst       = dst;
    bus.i_rt           = rt;
    bus.i_rd           = rd;
    {bus.i_branch, bus.i_memRead, bus.i_memWrite, bus.i_regWrite, bus.i_memToReg, bus.i_jump} = ctl;
  endtask

  task automatic rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    setin(3'd2, a, b, {26'd0, f}, 32'h0000_0040, 1'b0, 1'b1, 5'd2, rd, 6'b000100);
  endtask

  task automatic rand_inputs();
    logic [31:0] r;
    r = $urandom;
    setin(r[2:0], $urandom, $urandom, $urandom, $urandom, r[3], r[4], r[9:5], r[14:10], r[20:15]);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_stall();
    int n;
    n = 0;
    while (bus.o_stall === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) tmo_cnt++;
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lo, input logic [31:0] hi);
    nopins();
    rtype(6'h1A, a, b, 5'd0);
    step();
    pin_alu(lo);
    rtype(6'h12, 32'd0, 32'd0, 5'd3);
    wait_stall();
    pin_alu(hi);
    rtype(6'h10, 32'd0, 32'd0, 5'd3);
    step();
  endtask

  initial begin
    nopins();
    rst = 1'b1;
    rand_inputs();
    step();
    rand_inputs();
    step();
    rst = 1'b0;

    pin_alu(32'd0);
    rtype(6'h12, 32'd1, 32'd2, 5'd3);
    step();

    pins(1'b1, 32'hFFFF_FFFE, 1'b1, 5'd9, 1'b0, 32'd0, 1'b1, 1'b0);
    rtype(6'h22, 32'd5, 32'd7, 5'd9);
    step();
    pin_alu(32'd1);
    rtype(6'h2A, 32'd5, 32'd7, 5'd9);
    step();

    pins(1'b1, 32'h0000_000C, 1'b1, 5'd4, 1'b1, 32'h0000_00F0, 1'b1, 1'b0);
    setin(3'd0, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h100, 1'b1, 1'b0, 5'd4, 5'd7, 6'b100000);
    step();

    pin_alu(32'h00F0_1234);
    setin(3'd3, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0, 32'h200, 1'b0, 1'b1, 5'd1, 5'd5, 6'b000100);
    step();
    pin_alu(32'h0000_1234);
    setin(3'd4, 32'h1200, 32'h0034, 32'h0, 32'h204, 1'b0, 1'b1, 5'd1, 5'd6, 6'b000100);
    step();
    pin_alu(32'hABCD_0000);
    setin(3'd6, 32'h0, 32'h0, 32'h0000_ABCD, 32'h208, 1'b1, 1'b0, 5'd8, 5'd1, 6'b000100);
    step();
    pins(1'b1, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    setin(3'd0, 32'd5, 32'hFFFF_FFFB, 32'h0, 32'h20C, 1'b0, 1'b1, 5'd1, 5'd2, 6'b010110);
    step();
    pin_alu(32'd1);
    setin(3'd5, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h210, 1'b0, 1'b1, 5'd1, 5'd2, 6'b000100);
    step();
    pin_alu(32'd7);
    rtype(6'h00, 32'd3, 32'd4, 5'd10);
    step();
    pin_alu(32'h0000_001E);
    setin(3'd7, 32'd10, 32'd20, 32'h0, 32'h214, 1'b0, 1'b0, 5'd11, 5'd12, 6'b001000);
    step();

    nopins();
    rtype(6'h18, 32'hFFFF_FFFD, 32'h0001_0000, 5'd0);
    step();
    pin_alu(32'hFFFF_FFFF);
    rtype(6'h10, 32'd0, 32'd0, 5'd3);
    wait_stall();
    pin_alu(32'hFFFD_0000);
    rtype(6'h12, 32'd0, 32'd0, 5'd3);
    step();

    do_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

    nopins();
    rtype(6'h1A, 32'd100, 32'd7, 5'd0);
    step();
    rtype(6'h10, 32'd0, 32'd0, 5'd3);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    pin_alu(32'd0);
    rtype(6'h10, 32'd0, 32'd0, 5'd3);
    step();
    pin_alu(32'd0);
    rtype(6'h12, 32'd0, 32'd0, 5'd3);
    step();
    pin_alu(32'd7);
    setin(3'd0, 32'd3, 32'd4, 32'h0, 32'h300, 1'b0, 1'b1, 5'd1, 5'd13, 6'b000100);
    step();

    nopins();
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
